lfsr_bist_ctrl: RTL and testbench
=================================

LFSR_BIST_CTRL -- requirements
Module: lfsr_bist_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: LFSR, pattern, response and signature width; SHALL be at least 8.
REQ-002 Parameter CNT_W, default 16: pattern-count width.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  begin a test run; sampled only in IDLE.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 seed  input  WIDTH  LFSR seed, captured when start is accepted.
REQ-008 num_patterns  input  CNT_W  number of patterns per run, captured when start is accepted.
REQ-009 resp  input  WIDTH  DUT response to the current pattern, sampled in cycles where pattern_valid=1.
REQ-010 golden  input  WIDTH  expected signature, sampled in COMPARE.
REQ-011 pattern  output  WIDTH  current LFSR pattern to the DUT.
REQ-012 pattern_valid  output  1  pattern is live this cycle.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 pass  output  1  signature matched golden; held until the next accepted start.
REQ-016 signature  output  WIDTH  final MISR value; held until the next accepted start.

Function
REQ-017 FSM states SHALL be IDLE, SEED, RUN, COMPARE, DONE.
REQ-018 IDLE with start=1 SHALL go to SEED and capture seed and num_patterns; start in any other state SHALL be ignored.
REQ-019 SEED (one cycle) SHALL do all of the following:
- load the LFSR with the captured seed, substituting all-ones if seed==0 (lockup avoidance);
- load the counter with num_patterns;
- clear the MISR to 0;
- clear pass.
REQ-020 SEED SHALL go to RUN if the count is nonzero, otherwise to COMPARE.
REQ-021 In RUN, pattern_valid=1 and pattern=LFSR for exactly num_patterns consecutive cycles.
REQ-022 In each RUN cycle:
- LFSR steps: next = {p[WIDTH-2:0], p[WIDTH-1]^p[6]};
- MISR updates: next = {s[WIDTH-2:0], s[WIDTH-1]^s[6]} XOR resp;
- counter decrements by 1.
REQ-023 RUN SHALL go to COMPARE on the cycle the counter reaches 1 before decrementing; the counter SHALL NOT wrap.
REQ-024 COMPARE (one cycle) SHALL register signature=MISR and pass=(MISR==golden), then go to DONE.
REQ-025 DONE (one cycle) SHALL assert done=1, then go to IDLE.
REQ-026 Latency: done SHALL assert num_patterns+3 cycles after the start-accept edge.
REQ-027 abort=1 in SEED, RUN or COMPARE SHALL go to IDLE on the next edge with pass=0, no done pulse, and signature unchanged.
REQ-028 If abort and the final RUN cycle coincide, abort SHALL win.
REQ-029 Outside RUN, pattern SHALL hold its last value and pattern_valid SHALL be 0.
REQ-030 start asserted in the same cycle as done SHALL be ignored; a new run SHALL be accepted from IDLE on the following cycle.

Reset
REQ-031 rst=1 SHALL immediately force:
- state=IDLE;
- LFSR=all-ones;
- MISR=0, counter=0;
- pattern=all-ones;
- pattern_valid=0, busy=0, done=0, pass=0, signature=0.
REQ-032 Reset asserted mid-run SHALL discard the run with no done pulse.
REQ-033 The first accepted start after reset deassertion SHALL behave as REQ-018.

Structure
REQ-034 Shared package lfsr_pkg SHALL hold:
- the FSM state enum;
- the tap index constant (6);
- the all-ones lockup seed constant.
REQ-035 One sub-module, lfsr_load, SHALL implement the loadable LFSR; the controller SHALL contain the FSM, counter and MISR.
REQ-036 Target implementation size is 120-400 lines of RTL.

Verification
REQ-037 Reset: assert rst mid-RUN -> all outputs at reset values within the same cycle; no done pulse.
REQ-038 Loopback (resp=pattern), seed=10'h3FF, N=3, golden=10'h3FC:
- patterns SHALL be 3FF, 3FE, 3FC;
- signature=3FC, pass=1;
- done SHALL assert 6 cycles after start is accepted.
REQ-039 Same stimulus as REQ-038 with golden=10'h000 -> signature=3FC, pass=0, done pulse issued.
REQ-040 seed=0, N=1 -> pattern=10'h3FF with pattern_valid high for exactly one cycle.
REQ-041 N=0 -> no pattern_valid, signature=0, pass=(golden==0), done 3 cycles after start is accepted.
REQ-042 abort on the 2nd RUN cycle of an N=5 run -> IDLE next cycle, no done, pass=0, busy=0; start re-asserted while busy -> ignored.

Source files
------------

// File: rtl/lfsr_pkg.sv
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared FSM state type and LFSR constants for the BIST controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lfsr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEED    = 3'd1,
        ST_RUN     = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Second feedback tap; the first tap is always the MSB.
    localparam int C_TAP_IDX = 6;

    // Widest supported LFSR; users slice the low WIDTH bits.
    localparam int                   C_MAX_WIDTH   = 64;
    localparam logic [C_MAX_WIDTH-1:0] C_LOCKUP_SEED = '1;

endpackage

`default_nettype wire

// File: rtl/lfsr_load.sv
// ============================================================================
// Module      : lfsr_load
// Description : Loadable Fibonacci LFSR; an all-zero seed is replaced by all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_load
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] next_o
);

    generate
        if (WIDTH < 8 || WIDTH > C_MAX_WIDTH) begin : g_width_check
            $error("lfsr_load: WIDTH out of supported range");
        end
    endgenerate

    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] lfsr_d;
    logic [WIDTH-1:0] seed_eff;

    always_comb begin
        seed_eff = (seed_i == '0) ? C_LOCKUP_SEED[WIDTH-1:0] : seed_i;
        lfsr_d   = lfsr_q;
        if (load_i) begin
            lfsr_d = seed_eff;
        end else if (step_i) begin
            lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[WIDTH-1] ^ lfsr_q[C_TAP_IDX]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= C_LOCKUP_SEED[WIDTH-1:0];
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Exposing the next value lets the controller register the pattern in step with the LFSR.
    assign next_o = lfsr_d;

endmodule

`default_nettype wire

// File: rtl/lfsr_bist_ctrl.sv
// ============================================================================
// Module      : lfsr_bist_ctrl
// Description : LFSR pattern BIST controller with MISR signature compaction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lfsr_bist_ctrl
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] seed,
    input  logic [CNT_W-1:0] num_patterns,
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] golden,
    output logic [WIDTH-1:0] pattern,
    output logic             pattern_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature
);

    state_t           state_q;
    logic [WIDTH-1:0] seed_q;
    logic [CNT_W-1:0] npat_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] misr_q;
    logic [WIDTH-1:0] misr_d;
    logic [WIDTH-1:0] pattern_q;
    logic             pattern_valid_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [WIDTH-1:0] signature_q;
    logic [WIDTH-1:0] lfsr_next;
    logic             lfsr_load_en;
    logic             lfsr_step_en;

    assign lfsr_load_en = (state_q == ST_SEED);
    assign lfsr_step_en = (state_q == ST_RUN);

    lfsr_load #(
        .WIDTH (WIDTH)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load_en),
        .step_i (lfsr_step_en),
        .seed_i (seed_q),
        .next_o (lfsr_next)
    );

    always_comb begin
        misr_d = {misr_q[WIDTH-2:0], misr_q[WIDTH-1] ^ misr_q[C_TAP_IDX]} ^ resp;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            seed_q          <= '0;
            npat_q          <= '0;
            cnt_q           <= '0;
            misr_q          <= '0;
            pattern_q       <= C_LOCKUP_SEED[WIDTH-1:0];
            pattern_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
            signature_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_q  <= seed;
                        npat_q  <= num_patterns;
                        state_q <= ST_SEED;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SEED: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        cnt_q  <= npat_q;
                        misr_q <= '0;
                        pass_q <= 1'b0;
                        if (npat_q != '0) begin
                            state_q         <= ST_RUN;
                            pattern_valid_q <= 1'b1;
                            pattern_q       <= lfsr_next;
                        end else begin
                            state_q <= ST_COMPARE;
                        end
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state_q         <= ST_IDLE;
                        pattern_valid_q <= 1'b0;
                        busy_q          <= 1'b0;
                        pass_q          <= 1'b0;
                    end else begin
                        misr_q <= misr_d;
                        cnt_q  <= cnt_q - 1'b1;
                        // Pattern freezes on the last RUN cycle even though the LFSR keeps stepping.
                        if (cnt_q == CNT_W'(1)) begin
                            state_q         <= ST_COMPARE;
                            pattern_valid_q <= 1'b0;
                        end else begin
                            pattern_q <= lfsr_next;
                        end
                    end
                end
                ST_COMPARE: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else begin
                        signature_q <= misr_q;
                        pass_q      <= (misr_q == golden);
                        state_q     <= ST_DONE;
                        done_q      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q         <= ST_IDLE;
                    pattern_valid_q <= 1'b0;
                    busy_q          <= 1'b0;
                    done_q          <= 1'b0;
                end
            endcase
        end
    end

    assign pattern       = pattern_q;
    assign pattern_valid = pattern_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign signature     = signature_q;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_bist_ctrl.sv
// ============================================================================
// Module      : tb_lfsr_bist_ctrl
// Description : Self-checking bench for lfsr_bist_ctrl against a run-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lfsr_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [9:0]  seed;
    logic [15:0] num_patterns;
    logic [9:0]  resp;
    logic [9:0]  golden;
    logic [9:0]  pattern;
    logic        pattern_valid;
    logic        busy;
    logic        done;
    logic        pass;
    logic [9:0]  signature;

    int n_checks = 0;
    int n_pass   = 0;

    logic [9:0] o_pat[$];
    logic [9:0] e_pat[$];
    logic [9:0] e_sig;
    logic [9:0] resp_plan[64];
    int         done_cyc;
    int         done_cnt;
    int         valid_cnt;
    bit         timed_out;
    bit         idle_after_done;

    lfsr_bist_ctrl #(
        .WIDTH (10),
        .CNT_W (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .seed          (seed),
        .num_patterns  (num_patterns),
        .resp          (resp),
        .golden        (golden),
        .pattern       (pattern),
        .pattern_valid (pattern_valid),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .signature     (signature)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] ref_next(input logic [9:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    // Expected pattern list and signature for a complete run.
    task automatic model(input logic [9:0] s, input int n, input bit loop);
        logic [9:0] p;
        logic [9:0] m;
        logic [9:0] r;
        e_pat.delete();
        p = (s == 10'h000) ? 10'h3FF : s;
        m = 10'h000;
        for (int i = 0; i < n; i++) begin
            e_pat.push_back(p);
            r = loop ? p : resp_plan[i % 64];
            m = ref_next(m) ^ r;
            p = ref_next(p);
        end
        e_sig = m;
    endtask

    // Drives one run and records observations; cycle 1 is the cycle after the accept edge.
    task automatic do_run(input logic [9:0] s, input logic [15:0] n, input logic [9:0] g,
                          input bit loop, input int abort_idx, input bit poke_busy,
                          input bit poke_done);
        int cyc;
        int ridx;
        bit poke_pending;
        o_pat.delete();
        done_cyc = -1; done_cnt = 0; valid_cnt = 0; timed_out = 0; idle_after_done = 0;
        @(negedge clk);
        seed = s; num_patterns = n; golden = g; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        seed = 10'($urandom);
        num_patterns = 16'($urandom_range(1, 4));
        cyc = 1; ridx = 0; poke_pending = 0;
        forever begin
            if (poke_pending) begin
                idle_after_done = !busy;
                start = 1'b0;
                poke_pending = 0;
            end
            if (pattern_valid) begin
                o_pat.push_back(pattern);
                resp = loop ? pattern : resp_plan[ridx % 64];
                ridx++;
                valid_cnt++;
                if (ridx == abort_idx) abort = 1'b1;
                if (poke_busy && ridx == 1) start = 1'b1;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
                if (poke_done) begin
                    start = 1'b1;
                    poke_pending = 1;
                end
            end
            if (!busy && !poke_pending) break;
            if (cyc > int'(n) + 20) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            if (!poke_pending) start = 1'b0;
            cyc++;
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #3;
        n_checks++;
        if ({pattern, pattern_valid, busy, done, pass, signature} !== {10'h3FF, 4'b0000, 10'h000}) begin
            $display("FAIL reset_outputs: got pat=%h pv=%b busy=%b done=%b pass=%b sig=%h, want 3ff 0 0 0 0 000",
                     pattern, pattern_valid, busy, done, pass, signature);
        end else n_pass++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_loopback;
        model(10'h3FF, 3, 1);
        do_run(10'h3FF, 16'd3, 10'h3FC, 1, 0, 0, 0);
        n_checks++;
        if (o_pat.size() != 3 || o_pat[0] !== 10'h3FF || o_pat[1] !== 10'h3FE || o_pat[2] !== 10'h3FC) begin
            $display("FAIL loopback_patterns: got %p, want 3ff 3fe 3fc", o_pat);
        end else n_pass++;
        n_checks++;
        if (signature !== 10'h3FC || e_sig !== 10'h3FC) begin
            $display("FAIL loopback_signature: got %h (model %h), want 3fc", signature, e_sig);
        end else n_pass++;
        n_checks++;
        if (pass !== 1'b1) $display("FAIL loopback_pass: got %b, want 1", pass);
        else n_pass++;
        n_checks++;
        if (done_cyc != 6 || done_cnt != 1 || timed_out) begin
            $display("FAIL loopback_latency: done at cycle %0d x%0d timeout=%0d, want cycle 6 x1",
                     done_cyc, done_cnt, timed_out);
        end else n_pass++;
    endtask

    task automatic test_golden_mismatch;
        do_run(10'h3FF, 16'd3, 10'h000, 1, 0, 0, 0);
        n_checks++;
        if (signature !== 10'h3FC || pass !== 1'b0 || done_cnt != 1) begin
            $display("FAIL mismatch_result: got sig=%h pass=%b dones=%0d, want 3fc 0 1",
                     signature, pass, done_cnt);
        end else n_pass++;
    endtask

    task automatic test_zero_seed;
        do_run(10'h000, 16'd1, 10'h155, 1, 0, 0, 0);
        n_checks++;
        if (valid_cnt != 1 || o_pat.size() != 1 || o_pat[0] !== 10'h3FF) begin
            $display("FAIL zero_seed: got %0d valid cycles pat=%p, want 1 cycle of 3ff", valid_cnt, o_pat);
        end else n_pass++;
        n_checks++;
        if (signature !== 10'h3FF || pass !== 1'b0) begin
            $display("FAIL zero_seed_sig: got sig=%h pass=%b, want 3ff 0", signature, pass);
        end else n_pass++;
    endtask

    task automatic test_zero_count;
        logic [9:0] g;
        for (int k = 0; k < 2; k++) begin
            g = (k == 0) ? 10'h000 : 10'h2A5;
            do_run(10'($urandom), 16'd0, g, 0, 0, 0, 0);
            n_checks++;
            if (valid_cnt != 0 || signature !== 10'h000 || pass !== (g == 10'h000) || done_cyc != 3) begin
                $display("FAIL zero_count_%0d: got valid=%0d sig=%h pass=%b done_cyc=%0d, want 0 000 %b 3",
                         k, valid_cnt, signature, pass, done_cyc, (g == 10'h000));
            end else n_pass++;
        end
    endtask

    task automatic test_abort;
        logic [9:0] sig_before;
        sig_before = signature;
        for (int i = 0; i < 64; i++) resp_plan[i] = 10'($urandom);
        model(10'h1A3, 5, 0);
        do_run(10'h1A3, 16'd5, e_sig, 0, 2, 1, 0);
        n_checks++;
        if (valid_cnt != 2 || done_cnt != 0 || busy !== 1'b0 || pass !== 1'b0 || timed_out) begin
            $display("FAIL abort_state: got valid=%0d dones=%0d busy=%b pass=%b, want 2 0 0 0",
                     valid_cnt, done_cnt, busy, pass);
        end else n_pass++;
        n_checks++;
        if (signature !== sig_before) $display("FAIL abort_signature: got %h, want %h", signature, sig_before);
        else n_pass++;
        n_checks++;
        if (o_pat.size() != 2 || o_pat[0] !== e_pat[0] || o_pat[1] !== e_pat[1]) begin
            $display("FAIL abort_start_ignored: got %p, want %h %h", o_pat, e_pat[0], e_pat[1]);
        end else n_pass++;
        repeat (3) begin
            @(posedge clk); #1;
            n_checks++;
            if (busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_quiet: got busy=%b done=%b, want 0 0", busy, done);
            else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [9:0] s;
        logic [9:0] g;
        int n;
        bit pat_ok;
        for (int it = 0; it < 16; it++) begin
            for (int i = 0; i < 64; i++) resp_plan[i] = 10'($urandom);
            s = (it % 5 == 0) ? 10'h000 : 10'($urandom);
            n = $urandom_range(0, 20);
            model(s, n, 0);
            g = $urandom_range(0, 1) ? e_sig : 10'($urandom);
            do_run(s, 16'(n), g, 0, 0, 0, 0);
            pat_ok = (o_pat.size() == e_pat.size());
            for (int i = 0; i < o_pat.size() && pat_ok; i++) pat_ok = (o_pat[i] === e_pat[i]);
            n_checks++;
            if (!pat_ok || valid_cnt != n) begin
                $display("FAIL rand%0d_patterns: got %0d cycles %p, want %0d cycles %p", it, valid_cnt, o_pat, n, e_pat);
            end else n_pass++;
            n_checks++;
            if (signature !== e_sig || pass !== (g == e_sig)) begin
                $display("FAIL rand%0d_result: got sig=%h pass=%b, want %h %b", it, signature, pass, e_sig, (g == e_sig));
            end else n_pass++;
            n_checks++;
            if (done_cyc != n + 3 || done_cnt != 1 || timed_out) begin
                $display("FAIL rand%0d_latency: got done_cyc=%0d dones=%0d, want %0d 1", it, done_cyc, done_cnt, n + 3);
            end else n_pass++;
        end
    endtask

    task automatic test_back_to_back;
        do_run(10'h0F0, 16'd2, 10'h000, 1, 0, 0, 1);
        n_checks++;
        if (idle_after_done !== 1'b1 || done_cnt != 1) begin
            $display("FAIL b2b_start_at_done: got idle_after=%b dones=%0d, want 1 1", idle_after_done, done_cnt);
        end else n_pass++;
        model(10'h3FF, 3, 1);
        do_run(10'h3FF, 16'd3, 10'h3FC, 1, 0, 0, 0);
        n_checks++;
        if (done_cyc != 6 || signature !== e_sig || pass !== 1'b1) begin
            $display("FAIL b2b_next_run: got done_cyc=%0d sig=%h pass=%b, want 6 %h 1", done_cyc, signature, pass, e_sig);
        end else n_pass++;
    endtask

    task automatic test_reset_midrun;
        int seen_done;
        @(negedge clk);
        seed = 10'h2C1; num_patterns = 16'd8; golden = 10'h000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({pattern, pattern_valid, busy, done, pass, signature} !== {10'h3FF, 4'b0000, 10'h000}) begin
            $display("FAIL reset_midrun: got pat=%h pv=%b busy=%b done=%b pass=%b sig=%h, want 3ff 0 0 0 0 000",
                     pattern, pattern_valid, busy, done, pass, signature);
        end else n_pass++;
        seen_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen_done++;
        end
        n_checks++;
        if (seen_done != 0) $display("FAIL reset_no_done: got %0d active cycles, want 0", seen_done);
        else n_pass++;
        model(10'h3FF, 3, 1);
        do_run(10'h3FF, 16'd3, 10'h3FC, 1, 0, 0, 0);
        n_checks++;
        if (o_pat.size() != 3 || o_pat[2] !== e_pat[2] || done_cyc != 6 || pass !== 1'b1) begin
            $display("FAIL reset_restart: got %p done_cyc=%0d pass=%b, want %p 6 1", o_pat, done_cyc, pass, e_pat);
        end else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        seed = '0; num_patterns = '0; resp = '0; golden = '0;
        for (int i = 0; i < 64; i++) resp_plan[i] = '0;
        test_reset();
        test_loopback();
        test_golden_mismatch();
        test_zero_seed();
        test_loopback();
        test_abort();
        test_zero_count();
        test_random();
        test_back_to_back();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
